// File: rtl/sub_seq.sv
// rtl/sub_seq.sv - multi-cycle signed subtractor, CHUNK_WIDTH bits per cycle, ready/valid on both sides.
// Optional saturation of the result on overflow: define SUB_SAT_EN.
module sub_seq #(
  parameter int ARG_WIDTH   = 32,
  parameter int RES_WIDTH   = ARG_WIDTH + 1,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arg_vld,
  output logic                 arg_rdy,
  input  logic [ARG_WIDTH-1:0] a,
  input  logic [ARG_WIDTH-1:0] b,
  output logic                 res_vld,
  input  logic                 res_rdy,
  output logic [RES_WIDTH-1:0] res,
  output logic                 overflow
);

  localparam int NCHUNK = ARG_WIDTH / CHUNK_WIDTH;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int EXT    = RES_WIDTH - ARG_WIDTH;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                 state_q, state_d;
  logic [ARG_WIDTH-1:0]   a_q, a_d;
  logic [ARG_WIDTH-1:0]   b_q, b_d;
  logic [ARG_WIDTH-1:0]   acc_q, acc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic                   carry_q, carry_d;
  logic [RES_WIDTH-1:0]   res_q, res_d;
  logic                   ovf_q, ovf_d;

  logic [CHUNK_WIDTH-1:0] a_chunk;
  logic [CHUNK_WIDTH-1:0] b_chunk;
  logic [CHUNK_WIDTH:0]   sum;
  logic [ARG_WIDTH-1:0]   low;
  logic                   sign_bit;
  logic                   accept;

  assign arg_rdy  = !rst && ((state_q == IDLE) || ((state_q == DONE) && res_rdy));
  assign accept   = arg_vld && arg_rdy;
  assign res_vld  = (state_q == DONE);
  assign res      = res_q;
  assign overflow = ovf_q;

  // One chunk of a + ~b + carry per cycle.
  assign a_chunk = a_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign b_chunk = b_q[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH];
  assign sum     = {1'b0, a_chunk} + {1'b0, ~b_chunk} + {{CHUNK_WIDTH{1'b0}}, carry_q};

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    low      = acc_q;
    low[idx_q*CHUNK_WIDTH +: CHUNK_WIDTH] = sum[CHUNK_WIDTH-1:0];
    // Sign of the (ARG_WIDTH+1)-bit sign-extended difference.
    sign_bit = a_q[ARG_WIDTH-1] ^ ~b_q[ARG_WIDTH-1] ^ sum[CHUNK_WIDTH];

    case (state_q)
      IDLE: ;
      CALC: begin
        acc_d   = low;
        carry_d = sum[CHUNK_WIDTH];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = DONE;
          res_d   = {{EXT{sign_bit}}, low};
          ovf_d   = sign_bit ^ low[ARG_WIDTH-1];
`ifdef SUB_SAT_EN
          if (sign_bit ^ low[ARG_WIDTH-1])
            res_d = {{EXT{sign_bit}}, sign_bit, {(ARG_WIDTH-1){~sign_bit}}};
`endif
        end
      end
      DONE: if (res_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      a_d     = a;
      b_d     = b;
      acc_d   = '0;
      idx_d   = '0;
      carry_d = 1'b1;
      state_d = CALC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sub_seq.sv
// tb/tb_sub_seq.sv - directed vectors for sub_seq at default widths (32/33/8).
module tb_sub_seq;

  localparam int AW = 32;
  localparam int RW = 33;

`ifdef SUB_SAT_EN
  localparam logic [RW-1:0] EXP_NEG_OVF = 33'h1_8000_0000;
  localparam logic [RW-1:0] EXP_POS_OVF = 33'h0_7FFF_FFFF;
`else
  localparam logic [RW-1:0] EXP_NEG_OVF = 33'h1_7FFF_FFFF;
  localparam logic [RW-1:0] EXP_POS_OVF = 33'h0_8000_0000;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          arg_vld;
  logic          arg_rdy;
  logic [AW-1:0] a;
  logic [AW-1:0] b;
  logic          res_vld;
  logic          res_rdy;
  logic [RW-1:0] res;
  logic          overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sub_seq #(.ARG_WIDTH(AW), .RES_WIDTH(RW), .CHUNK_WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .arg_vld  (arg_vld),
    .arg_rdy  (arg_rdy),
    .a        (a),
    .b        (b),
    .res_vld  (res_vld),
    .res_rdy  (res_rdy),
    .res      (res),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where res_vld is first seen (or on timeout).
  task automatic run_op(input string tag, input logic [AW-1:0] av, input logic [AW-1:0] bv,
                        input logic [RW-1:0] exp_res, input logic exp_ovf);
    int w;
    int lat;
    w = 0;
    arg_vld = 1'b1;
    a = av;
    b = bv;
    while (!arg_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_arg_rdy"}, arg_rdy, 1);
    @(posedge clk);
    @(negedge clk);
    arg_vld = 1'b0;
    a = ~av;
    b = $urandom;
    check({tag, "_vld_low"}, res_vld, 0);
    lat = 0;
    while (!res_vld && lat < 20) begin
      check({tag, "_rdy_calc"}, arg_rdy, 0);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_ovf"}, overflow, exp_ovf);
  endtask

  initial begin
    rst     = 1'b1;
    arg_vld = 1'b1;
    a       = 32'd1;
    b       = 32'd2;
    res_rdy = 1'b1;
    @(negedge clk);
    check("rst_vld", res_vld, 0);
    check("rst_res", res, 0);
    check("rst_ovf", overflow, 0);
    check("rst_rdy", arg_rdy, 0);
    rst = 1'b0;
    arg_vld = 1'b0;
    #1;
    check("post_rst_rdy", arg_rdy, 1);
    @(negedge clk);

    run_op("small",     32'd5,          32'd3,          33'h0_0000_0002, 1'b0);
    run_op("borrow",    32'h0000_0100,  32'd1,          33'h0_0000_00FF, 1'b0);
    run_op("neg_ovf",   32'h8000_0000,  32'd1,          EXP_NEG_OVF,     1'b1);
    run_op("zero_min",  32'h0000_0000,  32'h8000_0000,  EXP_POS_OVF,     1'b1);
    run_op("mixed",     32'hFFFF_FFF0,  32'h0000_0010,  33'h1_FFFF_FFE0, 1'b0);
    @(negedge clk);
    check("idle_vld", res_vld, 0);
    check("idle_res_hold", res, 33'h1_FFFF_FFE0);

    res_rdy = 1'b0;
    run_op("pos_ovf",   32'h7FFF_FFFF,  32'hFFFF_FFFF,  EXP_POS_OVF,     1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_vld", res_vld, 1);
      check("bp_res", res, EXP_POS_OVF);
      check("bp_ovf", overflow, 1);
      check("bp_rdy", arg_rdy, 0);
    end
    res_rdy = 1'b1;
    run_op("b2b",       32'd10,         32'd20,         33'h1_FFFF_FFF6, 1'b0);

    run_op("pre_rst",   32'd100,        32'd1,          33'h0_0000_0063, 1'b0);
    arg_vld = 1'b1;
    a = 32'd50;
    b = 32'd1;
    @(posedge clk);
    @(negedge clk);
    arg_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_vld", res_vld, 0);
    check("mid_rst_res", res, 0);
    check("mid_rst_ovf", overflow, 0);
    check("mid_rst_rdy", arg_rdy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("after_rst_rdy", arg_rdy, 1);
    check("after_rst_vld", res_vld, 0);
    @(negedge clk);
    run_op("neg_eq",    32'hFFFF_FFF9,  32'hFFFF_FFF9,  33'h0_0000_0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
